xc_malu_seq: RTL and testbench
==============================

Name: xc_malu_seq

Overview:
- Sequencer and register owner that drives the multi-cycle muldivrem step unit.
- Accepts one operation at a time from the issue stage and holds the operands and op/width flags stable.
- Owns the count, acc, arg_0 and arg_1 state registers and feeds them to the step unit each cycle, writing back the step unit's next-state outputs.
- Contains the packed adder the step unit borrows; returns the 64-bit result to writeback over a valid/ready handshake.

Parameters:
- CNT_W, 6, width of the step counter (matches step-unit count port).

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- op_valid  in  1  issue has an operation.
- op_ready  out  1  sequencer accepts (IDLE only).
- op_rs1/op_rs2/op_rs3  in  32 each  source operands.
- op_sel  in  10  one-hot {pclmul,pmul,clmul,mulsu,mulu,mul,remu,rem,divu,div}, bit0=div.
- op_pw  in  5  one-hot {pw_2,pw_4,pw_8,pw_16,pw_32}, bit0=pw_32.
- flush  in  1  abandon current operation.
- out_valid  out  1  result available.
- out_ready  in  1  writeback consumes result.
- out_result  out  64  captured result.
- su_rs1/su_rs2/su_rs3  out  32 each  latched operands to step unit.
- su_valid  out  1  high in RUN.
- su_flush  out  1  equals flush.
- su_op  out  10  latched op_sel.
- su_pw  out  5  latched op_pw.
- su_count  out  CNT_W  count register.
- su_acc  out  64  acc register.
- su_arg_0/su_arg_1  out  32 each  arg registers.
- su_n_acc  in  64  next acc.
- su_n_arg_0/su_n_arg_1  in  32 each  next args.
- su_padd_lhs/su_padd_rhs  in  32 each  adder inputs.
- su_padd_sub/su_padd_cin/su_padd_cen  in  1 each  adder controls.
- su_padd_cout  out  33  adder carries.
- su_padd_result  out  32  adder sum.
- su_result  in  64  step-unit result.
- su_ready  in  1  step unit finished.

Behaviour:
- Reset (async, active-high): state=IDLE; all registers 0. Outputs: op_ready=1, out_valid=0, out_result=0, su_valid=0, su_count/su_acc/su_arg_*=0.
- FSM states: IDLE, RUN, DONE.
- IDLE: op_ready=1. On op_valid:
  - latch rs1..rs3, op_sel, op_pw;
  - clear count, acc, arg_0, arg_1 to 0;
  - go to RUN.
- RUN: su_valid=1. Each cycle:
  - if su_ready=0: acc<=su_n_acc, arg_0<=su_n_arg_0, arg_1<=su_n_arg_1, count<=count+1 (wraps mod 2^CNT_W).
  - if su_ready=1: out_result<=su_result, state regs unchanged, go to DONE.
- DONE: out_valid=1; out_result held stable. On out_ready go to IDLE. The next op is accepted no earlier than the cycle after the handshake.
- Latency: accept at cycle T, first RUN cycle T+1. If su_ready is first seen with count=k, out_valid rises at T+k+2.
- flush:
  - in any state, next state=IDLE, out_valid deasserts next cycle, and no result is delivered;
  - flush in IDLE together with op_valid: the op is not accepted and op_ready is forced low that cycle;
  - flush overrides out_ready.
- Reset mid-operation: identical to power-on reset, with no residual out_valid.
- Invalid op_sel (zero or multi-hot) is latched as given; the step unit's behaviour on it is undefined.
- Packed adder, combinational, element width W from su_pw:
  - rhs' = su_padd_sub ? ~rhs : rhs;
  - carry into bit i = (i mod W == 0) ? (su_padd_cin | su_padd_sub) : (su_padd_cen & carry out of bit i-1);
  - su_padd_result[i] = lhs[i]^rhs'[i]^cin_i;
  - su_padd_cout[i+1] = carry out of bit i; su_padd_cout[0] = carry into bit 0;
  - su_padd_cen=0 with sub=0 and cin=0 gives pure XOR (carryless).

Optional Feature:
- Macro XC_MALU_SEQ_TIMEOUT_EN.
- Defined:
  - adds output port out_err (1 bit), reset 0;
  - if count reaches 2^CNT_W-1 in RUN with su_ready=0, go to DONE with out_result=0 and out_err=1;
  - out_err clears on the handshake that leaves DONE.
- Not defined:
  - no out_err port; count wraps silently and RUN continues until su_ready or flush.

Decomposition:
- Shared package xc_malu_pkg holds:
  - op_sel bit index constants;
  - op_pw bit index constants;
  - FSM state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - CNT_W default.
- One sub-module: xc_malu_padd (packed adder, purely combinational), instantiated once.

Test Plan:
- mul, rs1=7, rs2=0xFFFFFFFD, with the real step unit -> out_result=0xFFFFFFFF_FFFFFFEB; out_valid held until out_ready.
- divu, rs1=100, rs2=7 -> out_result=0x00000000_0000000E. rem, rs1=0xFFFFFFF9, rs2=2 -> out_result[31:0]=0xFFFFFFFF.
- Back-pressure: out_ready low 5 cycles in DONE -> out_result stable, op_ready=0 throughout; one-cycle out_ready -> IDLE, op_ready=1 next cycle.
- flush at RUN count=10 -> IDLE next cycle, out_valid never asserts; following divu 9/3 -> result 3.
- Packed adder, pw_8, lhs=0x80FF0001, rhs=0x80010001, sub=0, cin=0, cen=1 -> su_padd_result=0x00000002, no carry across byte boundaries.
- Reset asserted mid-RUN -> all outputs at reset values immediately (async); with XC_MALU_SEQ_TIMEOUT_EN and a stub with su_ready tied 0 -> out_valid=1, out_err=1, out_result=0 after count=63.

Source files
------------

// File: rtl/xc_malu_pkg.sv
// Shared constants for the muldivrem sequencer: op/width one-hot bit
// positions, FSM state encodings and the default step-counter width.
package xc_malu_pkg;

  localparam int CNT_W_DEF = 6;

  // op_sel one-hot bit positions
  localparam int OP_DIV    = 0;
  localparam int OP_DIVU   = 1;
  localparam int OP_REM    = 2;
  localparam int OP_REMU   = 3;
  localparam int OP_MUL    = 4;
  localparam int OP_MULU   = 5;
  localparam int OP_MULSU  = 6;
  localparam int OP_CLMUL  = 7;
  localparam int OP_PMUL   = 8;
  localparam int OP_PCLMUL = 9;

  // op_pw one-hot bit positions
  localparam int PW_32 = 0;
  localparam int PW_16 = 1;
  localparam int PW_8  = 2;
  localparam int PW_4  = 3;
  localparam int PW_2  = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/xc_malu_padd.sv
// Packed 32-bit adder/subtractor lent to the step unit. Element width comes
// from the one-hot pw; carries are cut at element boundaries.
module xc_malu_padd
  import xc_malu_pkg::*;
(
  input  logic [4:0]  pw,
  input  logic [31:0] lhs,
  input  logic [31:0] rhs,
  input  logic        sub,
  input  logic        cin,
  input  logic        cen,
  output logic [32:0] cout,
  output logic [31:0] result
);

  logic [31:0] bnd;
  logic [31:0] rx;
  logic        c;
  logic        ci;

  // bnd[i] marks the lowest bit of each element; unknown pw falls back to 32
  always_comb begin
    bnd = 32'h0000_0001;
    if      (pw[PW_2])  bnd = 32'h5555_5555;
    else if (pw[PW_4])  bnd = 32'h1111_1111;
    else if (pw[PW_8])  bnd = 32'h0101_0101;
    else if (pw[PW_16]) bnd = 32'h0001_0001;
  end

  always_comb begin
    rx     = sub ? ~rhs : rhs;
    c      = 1'b0;
    ci     = 1'b0;
    cout   = '0;
    result = '0;
    for (int i = 0; i < 32; i++) begin
      ci        = bnd[i] ? (cin | sub) : (cen & c);
      result[i] = lhs[i] ^ rx[i] ^ ci;
      c         = (lhs[i] & rx[i]) | (lhs[i] & ci) | (rx[i] & ci);
      cout[i+1] = c;
      if (i == 0) cout[0] = ci;
    end
  end

endmodule

// File: rtl/xc_malu_seq.sv
// Sequencer/register owner for the multi-cycle muldivrem step unit.
// Optional XC_MALU_SEQ_TIMEOUT_EN: abort with out_err when the counter saturates.
module xc_malu_seq
  import xc_malu_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
)(
  input  logic             clock,
  input  logic             reset,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [31:0]      op_rs1,
  input  logic [31:0]      op_rs2,
  input  logic [31:0]      op_rs3,
  input  logic [9:0]       op_sel,
  input  logic [4:0]       op_pw,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_result,
`ifdef XC_MALU_SEQ_TIMEOUT_EN
  output logic             out_err,
`endif
  output logic [31:0]      su_rs1,
  output logic [31:0]      su_rs2,
  output logic [31:0]      su_rs3,
  output logic             su_valid,
  output logic             su_flush,
  output logic [9:0]       su_op,
  output logic [4:0]       su_pw,
  output logic [CNT_W-1:0] su_count,
  output logic [63:0]      su_acc,
  output logic [31:0]      su_arg_0,
  output logic [31:0]      su_arg_1,
  input  logic [63:0]      su_n_acc,
  input  logic [31:0]      su_n_arg_0,
  input  logic [31:0]      su_n_arg_1,
  input  logic [31:0]      su_padd_lhs,
  input  logic [31:0]      su_padd_rhs,
  input  logic             su_padd_sub,
  input  logic             su_padd_cin,
  input  logic             su_padd_cen,
  output logic [32:0]      su_padd_cout,
  output logic [31:0]      su_padd_result,
  input  logic [63:0]      su_result,
  input  logic             su_ready
);

  state_e state, state_n;
  logic   accept;
  logic   cnt_max;

  assign su_flush = flush;
  assign accept   = (state == S_IDLE) && op_valid && !flush;
  assign cnt_max  = &su_count;

  always_comb begin
    state_n   = state;
    op_ready  = 1'b0;
    su_valid  = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_IDLE: begin
        op_ready = !flush;
        if (accept) state_n = S_RUN;
      end
      S_RUN: begin
        su_valid = 1'b1;
        if (flush)         state_n = S_IDLE;
        else if (su_ready) state_n = S_DONE;
`ifdef XC_MALU_SEQ_TIMEOUT_EN
        else if (cnt_max)  state_n = S_DONE;
`endif
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (flush || out_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      su_rs1     <= '0;
      su_rs2     <= '0;
      su_rs3     <= '0;
      su_op      <= '0;
      su_pw      <= '0;
      su_count   <= '0;
      su_acc     <= '0;
      su_arg_0   <= '0;
      su_arg_1   <= '0;
      out_result <= '0;
`ifdef XC_MALU_SEQ_TIMEOUT_EN
      out_err    <= 1'b0;
`endif
    end else begin
      state <= state_n;
      case (state)
        S_IDLE: if (accept) begin
          su_rs1   <= op_rs1;
          su_rs2   <= op_rs2;
          su_rs3   <= op_rs3;
          su_op    <= op_sel;
          su_pw    <= op_pw;
          su_count <= '0;
          su_acc   <= '0;
          su_arg_0 <= '0;
          su_arg_1 <= '0;
        end
        S_RUN: if (!flush) begin
          if (su_ready) begin
            out_result <= su_result;
`ifdef XC_MALU_SEQ_TIMEOUT_EN
          end else if (cnt_max) begin
            out_result <= '0;
            out_err    <= 1'b1;
`endif
          end else begin
            su_acc   <= su_n_acc;
            su_arg_0 <= su_n_arg_0;
            su_arg_1 <= su_n_arg_1;
            su_count <= su_count + 1'b1;
          end
        end
        S_DONE: begin
`ifdef XC_MALU_SEQ_TIMEOUT_EN
          if (flush || out_ready) out_err <= 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end

  // no cnt_max use in the default build beyond this reduction
  logic unused_ok;
  assign unused_ok = cnt_max;

  xc_malu_padd u_padd (
    .pw     (su_pw),
    .lhs    (su_padd_lhs),
    .rhs    (su_padd_rhs),
    .sub    (su_padd_sub),
    .cin    (su_padd_cin),
    .cen    (su_padd_cen),
    .cout   (su_padd_cout),
    .result (su_padd_result)
  );

endmodule

// File: tb/tb_xc_malu_seq.sv
// Bench for xc_malu_seq: behavioural step-unit stub, vector tables and a
// result scoreboard, plus flush / reset / optional timeout sequences.
module tb_xc_malu_seq;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [31:0] op_rs1 = '0, op_rs2 = '0, op_rs3 = '0;
  logic [9:0]  op_sel = '0;
  logic [4:0]  op_pw = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_result;
`ifdef XC_MALU_SEQ_TIMEOUT_EN
  logic        out_err;
`endif
  logic [31:0] su_rs1, su_rs2, su_rs3;
  logic        su_valid, su_flush;
  logic [9:0]  su_op;
  logic [4:0]  su_pw;
  logic [5:0]  su_count;
  logic [63:0] su_acc;
  logic [31:0] su_arg_0, su_arg_1;
  logic [63:0] su_n_acc;
  logic [31:0] su_n_arg_0, su_n_arg_1;
  logic [31:0] padd_lhs = '0, padd_rhs = '0;
  logic        padd_sub = 1'b0, padd_cin = 1'b0, padd_cen = 1'b0;
  logic [32:0] padd_cout;
  logic [31:0] padd_result;
  logic [63:0] su_result;
  logic        su_ready;

  int          stub_k = 0;
  logic [63:0] stub_res = '0;

  // step-unit stub: accumulate rs1, toggle rs2, count in arg_1, finish at stub_k
  assign su_n_acc   = su_acc + {32'h0, su_rs1};
  assign su_n_arg_0 = su_arg_0 ^ su_rs2;
  assign su_n_arg_1 = su_arg_1 + 32'd1;
  assign su_ready   = su_valid && (32'(su_count) == stub_k);
  assign su_result  = su_ready ? stub_res : ~stub_res;

  always #5 clock = ~clock;

  xc_malu_seq dut (
    .clock(clock), .reset(reset),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_rs1(op_rs1), .op_rs2(op_rs2), .op_rs3(op_rs3),
    .op_sel(op_sel), .op_pw(op_pw), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
`ifdef XC_MALU_SEQ_TIMEOUT_EN
    .out_err(out_err),
`endif
    .su_rs1(su_rs1), .su_rs2(su_rs2), .su_rs3(su_rs3),
    .su_valid(su_valid), .su_flush(su_flush), .su_op(su_op), .su_pw(su_pw),
    .su_count(su_count), .su_acc(su_acc), .su_arg_0(su_arg_0), .su_arg_1(su_arg_1),
    .su_n_acc(su_n_acc), .su_n_arg_0(su_n_arg_0), .su_n_arg_1(su_n_arg_1),
    .su_padd_lhs(padd_lhs), .su_padd_rhs(padd_rhs),
    .su_padd_sub(padd_sub), .su_padd_cin(padd_cin), .su_padd_cen(padd_cen),
    .su_padd_cout(padd_cout), .su_padd_result(padd_result),
    .su_result(su_result), .su_ready(su_ready)
  );

  typedef struct {
    logic [9:0]  op;
    logic [4:0]  pw;
    logic [31:0] rs1, rs2, rs3;
    int          k;
    logic [63:0] res;
    int          bp;
  } op_vec_t;

  typedef struct {
    logic [4:0]  pw;
    logic [31:0] lhs, rhs;
    logic        sub, cin, cen;
    logic [31:0] res;
    logic        c32, c0;
  } padd_vec_t;

  int          total = 0;
  int          bad = 0;
  logic [63:0] sb[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic run_op(input op_vec_t v);
    int          lat;
    logic [63:0] held, exp;
    op_valid = 1'b1; op_sel = v.op; op_pw = v.pw;
    op_rs1 = v.rs1; op_rs2 = v.rs2; op_rs3 = v.rs3;
    stub_k = v.k; stub_res = v.res;
    #1 chk("op_ready_idle", 64'(op_ready), 64'd1);
    sb.push_back(v.res);
    @(posedge clock); #1;
    op_valid = 1'b0; op_rs1 = ~v.rs1; op_rs2 = ~v.rs2; op_rs3 = ~v.rs3;
    op_sel = ~v.op; op_pw = ~v.pw;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clock); #1;
      lat++;
    end
    chk("latency", 64'(lat), 64'(v.k + 2));
    if (!out_valid) begin
      void'(sb.pop_front());
      return;
    end
    chk("count", 64'(su_count), 64'(v.k));
    chk("acc", su_acc, {32'h0, v.rs1} * 64'(v.k));
    chk("arg_0", 64'(su_arg_0), (v.k % 2 == 1) ? 64'(v.rs2) : 64'd0);
    chk("arg_1", 64'(su_arg_1), 64'(v.k));
    chk("su_op", 64'(su_op), 64'(v.op));
    chk("su_pw", 64'(su_pw), 64'(v.pw));
    chk("su_rs3", 64'(su_rs3), 64'(v.rs3));
    held = out_result;
    for (int i = 0; i < v.bp; i++) begin
      @(posedge clock); #1;
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_op_ready", 64'(op_ready), 64'd0);
      chk("bp_stable", out_result, held);
    end
    out_ready = 1'b1;
    #1 exp = sb.pop_front();
    chk("result", out_result, exp);
    @(posedge clock); #1;
    out_ready = 1'b0;
    #1 chk("post_valid", 64'(out_valid), 64'd0);
    chk("post_op_ready", 64'(op_ready), 64'd1);
  endtask

  op_vec_t   ops[6];
  padd_vec_t pv[8];

  initial begin
    bit saw;
    int n;
    logic [4:0] cur_pw;
    op_vec_t pwop;

    ops[0] = '{10'h010, 5'h01, 32'd7, 32'hFFFF_FFFD, 32'd0, 3, 64'hFFFF_FFFF_FFFF_FFEB, 5};
    ops[1] = '{10'h002, 5'h01, 32'd100, 32'd7, 32'd0, 32, 64'h0000_0000_0000_000E, 0};
    ops[2] = '{10'h004, 5'h01, 32'hFFFF_FFF9, 32'd2, 32'd0, 33, 64'hFFFF_FFFF_FFFF_FFFF, 2};
    ops[3] = '{10'h200, 5'h04, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0BAD_F00D, 7, 64'h0123_4567_89AB_CDEF, 1};
    ops[4] = '{10'h000, 5'h01, 32'd5, 32'd6, 32'd7, 0, 64'h0000_0000_0000_0055, 0};
    ops[5] = '{10'h3FF, 5'h10, 32'hCAFE_0001, 32'd9, 32'd1, 63, 64'h0000_0000_0000_DEAD, 1};

    pv[0] = '{5'h04, 32'h80FF_0001, 32'h8001_0001, 1'b0, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0};
    pv[1] = '{5'h04, 32'h7F7F_7F7F, 32'h0101_0101, 1'b0, 1'b0, 1'b1, 32'h8080_8080, 1'b0, 1'b0};
    pv[2] = '{5'h01, 32'd5, 32'd3, 1'b1, 1'b0, 1'b1, 32'd2, 1'b1, 1'b1};
    pv[3] = '{5'h01, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 1'b0, 1'b0, 32'h0FF0_0FF0, 1'b1, 1'b0};
    pv[4] = '{5'h02, 32'h0001_FFFF, 32'h0001_0001, 1'b0, 1'b0, 1'b1, 32'h0002_0000, 1'b0, 1'b0};
    pv[5] = '{5'h02, 32'h0005_0003, 32'h0002_0005, 1'b1, 1'b0, 1'b1, 32'h0003_FFFE, 1'b1, 1'b1};
    pv[6] = '{5'h08, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1, 32'h1111_1111, 1'b0, 1'b1};
    pv[7] = '{5'h10, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1, 32'h5555_5555, 1'b0, 1'b1};

    // reset state
    #2;
    chk("rst_op_ready", 64'(op_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_result", out_result, 64'd0);
    chk("rst_su_valid", 64'(su_valid), 64'd0);
    chk("rst_acc", su_acc, 64'd0);
    chk("rst_args", {su_arg_1, su_arg_0}, 64'd0);
`ifdef XC_MALU_SEQ_TIMEOUT_EN
    chk("rst_out_err", 64'(out_err), 64'd0);
`endif
    @(posedge clock); #1 reset = 1'b0;
    @(posedge clock); #1;

    foreach (ops[i]) run_op(ops[i]);

    // flush mid-RUN at count 10
    op_valid = 1'b1; op_sel = 10'h002; op_pw = 5'h01; op_rs1 = 32'd50; op_rs2 = 32'd5;
    stub_k = 40; stub_res = 64'd10;
    @(posedge clock); #1 op_valid = 1'b0;
    n = 0;
    while (su_count != 6'd10 && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
    chk("flush_reach10", 64'(su_count), 64'd10);
    flush = 1'b1;
    #1 chk("su_flush", 64'(su_flush), 64'd1);
    @(posedge clock); #1 flush = 1'b0;
    #1 chk("flush_idle_ready", 64'(op_ready), 64'd1);
    chk("flush_su_valid", 64'(su_valid), 64'd0);
    saw = 1'b0;
    for (int i = 0; i < 45; i++) begin
      @(posedge clock); #1;
      if (out_valid) saw = 1'b1;
    end
    chk("flush_no_result", 64'(saw), 64'd0);

    // flush in IDLE blocks acceptance
    op_valid = 1'b1; flush = 1'b1;
    #1 chk("flush_blocks_ready", 64'(op_ready), 64'd0);
    @(posedge clock); #1 op_valid = 1'b0; flush = 1'b0;
    #1 chk("flush_not_accepted", 64'(su_valid), 64'd0);

    run_op('{10'h002, 5'h01, 32'd9, 32'd3, 32'd0, 5, 64'd3, 0});

    // packed adder: width comes from the latched pw, so issue a short op per width
    cur_pw = 5'h00;
    foreach (pv[i]) begin
      if (pv[i].pw != cur_pw) begin
        pwop = '{10'h010, pv[i].pw, 32'd1, 32'd1, 32'd0, 1, 64'd1, 0};
        run_op(pwop);
        cur_pw = pv[i].pw;
      end
      padd_lhs = pv[i].lhs; padd_rhs = pv[i].rhs;
      padd_sub = pv[i].sub; padd_cin = pv[i].cin; padd_cen = pv[i].cen;
      #1;
      chk($sformatf("padd_res%0d", i), 64'(padd_result), 64'(pv[i].res));
      chk($sformatf("padd_c32_%0d", i), 64'(padd_cout[32]), 64'(pv[i].c32));
      chk($sformatf("padd_c0_%0d", i), 64'(padd_cout[0]), 64'(pv[i].c0));
    end
    @(posedge clock); #1;

    // asynchronous reset mid-RUN
    op_valid = 1'b1; op_sel = 10'h010; op_pw = 5'h01; op_rs1 = 32'd3; op_rs2 = 32'd4;
    stub_k = 50; stub_res = 64'd1;
    @(posedge clock); #1 op_valid = 1'b0;
    repeat (5) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    chk("arst_su_valid", 64'(su_valid), 64'd0);
    chk("arst_count", 64'(su_count), 64'd0);
    chk("arst_acc", su_acc, 64'd0);
    chk("arst_out_result", out_result, 64'd0);
    chk("arst_op_ready", 64'(op_ready), 64'd1);
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    @(posedge clock); #1 reset = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      if (out_valid || su_valid) saw = 1'b1;
    end
    chk("arst_quiet", 64'(saw), 64'd0);

`ifdef XC_MALU_SEQ_TIMEOUT_EN
    // step unit never finishes: counter saturation forces an error completion
    op_valid = 1'b1; op_sel = 10'h001; op_pw = 5'h01; op_rs1 = 32'd1; op_rs2 = 32'd1;
    stub_k = 1000; stub_res = 64'hFFFF;
    @(posedge clock); #1 op_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 200) begin
      @(posedge clock); #1;
      n++;
    end
    chk("to_latency", 64'(n), 64'd65);
    chk("to_out_valid", 64'(out_valid), 64'd1);
    chk("to_out_err", 64'(out_err), 64'd1);
    chk("to_out_result", out_result, 64'd0);
    out_ready = 1'b1;
    @(posedge clock); #1 out_ready = 1'b0;
    #1 chk("to_err_clear", 64'(out_err), 64'd0);
    chk("to_idle", 64'(op_ready), 64'd1);
`endif

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
